// File: rtl/mem_config_queue.sv
// mem_config_queue
// Per-stream buffer-descriptor FIFOs filled from config-register writes and
// drained by the per-stream output writers. Also provides per-stream flush,
// and host-readable occupancy, consumed and dropped counters.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//                         (resynchronised internally before use)
//   write_valid_i/index_i/data_i
//                         config register write. Relative to WRITE_BASE:
//                         [0..N-1] enqueue, N flush mask, N+1 clear mask
//   read_valid_i/index_i  config register read request
//   read_valid_o/data_o   read response, one cycle after the request
//   out_buffer_*          per-stream descriptor ready/valid, FWFT
//   out_flush_buffers_o   per-stream one-cycle flush pulse
module mem_config_queue #(
  parameter int unsigned NUM_STREAMS                  = 2,
  parameter int unsigned MAXIMUM_NUM_ENQUEUED_BUFFERS = 8,
  parameter int unsigned FIFO_DEPTH                   = MAXIMUM_NUM_ENQUEUED_BUFFERS,
  parameter int unsigned WRITE_BASE                   = 0,
  parameter int unsigned AXIL_DATA_BITS               = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          write_valid_i,
  input  logic [31:0]                                   write_index_i,
  input  logic [AXIL_DATA_BITS-1:0]                     write_data_i,
  input  logic                                          read_valid_i,
  input  logic [31:0]                                   read_index_i,
  output logic                                          read_valid_o,
  output logic [AXIL_DATA_BITS-1:0]                     read_data_o,
  output logic [NUM_STREAMS-1:0][AXIL_DATA_BITS-1:0]    out_buffer_data_o,
  output logic [NUM_STREAMS-1:0]                        out_buffer_valid_o,
  input  logic [NUM_STREAMS-1:0]                        out_buffer_ready_i,
  output logic [NUM_STREAMS-1:0]                        out_flush_buffers_o
);

  localparam logic [31:0] MEM_CONFIG_QUEUE_ID = 32'h4D43_5130;
  localparam int unsigned OCC_BITS = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  if (NUM_STREAMS == 0) begin : g_bad_num_streams
    $error("mem_config_queue: NUM_STREAMS must be > 0");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_fifo_depth
    $error("mem_config_queue: FIFO_DEPTH must be >= 2");
  end
  if (AXIL_DATA_BITS < 32 || AXIL_DATA_BITS < NUM_STREAMS) begin : g_bad_data_bits
    $error("mem_config_queue: AXIL_DATA_BITS too narrow for counters or stream masks");
  end

  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Two-stage reset resynchroniser; everything else uses rst_int_n.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk) begin
    rst_sync_q <= {rst_sync_q[0], rst_n};
  end
  assign rst_int_n = rst_sync_q[1];

  // Write decode. The 33-bit subtract gives "index below base" as the borrow.
  logic [32:0] wr_diff;
  logic [31:0] wr_rel;
  logic        wr_hit, enq_hit, flush_hit, clear_hit;

  always_comb begin
    wr_diff   = {1'b0, write_index_i} - {1'b0, 32'(WRITE_BASE)};
    wr_rel    = wr_diff[31:0];
    wr_hit    = write_valid_i && !wr_diff[32];
    enq_hit   = wr_hit && (wr_rel < NUM_STREAMS);
    flush_hit = wr_hit && (wr_rel == NUM_STREAMS);
    clear_hit = wr_hit && (wr_rel == NUM_STREAMS + 1);
  end

  logic [OCC_BITS-1:0] occ_w      [NUM_STREAMS];
  logic [31:0]         consumed_w [NUM_STREAMS];
  logic [31:0]         dropped_w  [NUM_STREAMS];

  for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_stream
    logic [AXIL_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_BITS-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OCC_BITS-1:0]       count_q, count_d;
    logic [31:0]               consumed_q, consumed_d, dropped_q, dropped_d;
    logic                      flush_q, flush_d;
    logic                      valid, pop, push, push_ok, drop, clear;

    always_comb begin
      // Valid is masked during the flush cycle so no handshake can race the flush.
      valid    = (count_q != '0) && !flush_q;
      pop      = valid && out_buffer_ready_i[s];
      push     = enq_hit && (wr_rel == 32'(s));
      // A pop in the same cycle frees space for a push into a full FIFO.
      push_ok  = push && ((count_q != OCC_BITS'(FIFO_DEPTH)) || pop);
      // Pushes landing in the flush cycle are discarded by the flush, not dropped.
      drop     = push && !push_ok && !flush_q;
      clear    = clear_hit && write_data_i[s];
      flush_d  = flush_hit && write_data_i[s];

      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_q) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
      end

      consumed_d = consumed_q;
      dropped_d  = dropped_q;
      if (pop) consumed_d = consumed_q + 32'd1;
      if (drop && (dropped_q != '1)) dropped_d = dropped_q + 32'd1;
      // Clear wins over an event in the same cycle.
      if (clear) begin
        consumed_d = '0;
        dropped_d  = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_int_n) begin
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        consumed_q <= '0;
        dropped_q  <= '0;
        flush_q    <= 1'b0;
      end else begin
        rd_ptr_q   <= rd_ptr_d;
        wr_ptr_q   <= wr_ptr_d;
        count_q    <= count_d;
        consumed_q <= consumed_d;
        dropped_q  <= dropped_d;
        flush_q    <= flush_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push_ok && !flush_q) mem_q[wr_ptr_q] <= write_data_i;
    end

    assign out_buffer_valid_o[s]  = valid;
    assign out_buffer_data_o[s]   = mem_q[rd_ptr_q];
    assign out_flush_buffers_o[s] = flush_q;
    assign occ_w[s]               = count_q;
    assign consumed_w[s]          = consumed_q;
    assign dropped_w[s]           = dropped_q;
  end

  // Read register file, one cycle latency.
  logic [AXIL_DATA_BITS-1:0] rd_val;
  logic [AXIL_DATA_BITS-1:0] read_data_q, read_data_d;
  logic                      read_valid_q, read_valid_d;

  always_comb begin
    rd_val = '0;
    if (read_index_i == 32'd0)      rd_val = AXIL_DATA_BITS'(MEM_CONFIG_QUEUE_ID);
    else if (read_index_i == 32'd1) rd_val = AXIL_DATA_BITS'(NUM_STREAMS);
    else if (read_index_i == 32'd2) rd_val = AXIL_DATA_BITS'(FIFO_DEPTH);
    for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
      if (read_index_i == 3 + 3 * s) rd_val = AXIL_DATA_BITS'(occ_w[s]);
      if (read_index_i == 4 + 3 * s) rd_val = AXIL_DATA_BITS'(consumed_w[s]);
      if (read_index_i == 5 + 3 * s) rd_val = AXIL_DATA_BITS'(dropped_w[s]);
    end
    read_valid_d = read_valid_i;
    read_data_d  = read_valid_i ? rd_val : read_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_int_n) begin
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      read_valid_q <= read_valid_d;
      read_data_q  <= read_data_d;
    end
  end

  assign read_valid_o = read_valid_q;
  assign read_data_o  = read_data_q;

endmodule

// File: tb/tb_mem_config_queue.sv
// Testbench for mem_config_queue (NUM_STREAMS=2, FIFO_DEPTH=4, WRITE_BASE=16).
// Reference model: one SV queue of descriptors per stream plus plain counters.
module tb_mem_config_queue;
  localparam int unsigned NS    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BASE  = 16;
  localparam logic [31:0] ID    = 32'h4D43_5130;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              write_valid_i = 1'b0;
  logic [31:0]       write_index_i = '0;
  logic [31:0]       write_data_i = '0;
  logic              read_valid_i = 1'b0;
  logic [31:0]       read_index_i = '0;
  logic              read_valid_o;
  logic [31:0]       read_data_o;
  logic [NS-1:0][31:0] out_buffer_data_o;
  logic [NS-1:0]     out_buffer_valid_o;
  logic [NS-1:0]     out_buffer_ready_i = '0;
  logic [NS-1:0]     out_flush_buffers_o;

  always #5 clk = ~clk;

  mem_config_queue #(
    .NUM_STREAMS(NS),
    .FIFO_DEPTH (DEPTH),
    .WRITE_BASE (BASE)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .write_valid_i      (write_valid_i),
    .write_index_i      (write_index_i),
    .write_data_i       (write_data_i),
    .read_valid_i       (read_valid_i),
    .read_index_i       (read_index_i),
    .read_valid_o       (read_valid_o),
    .read_data_o        (read_data_o),
    .out_buffer_data_o  (out_buffer_data_o),
    .out_buffer_valid_o (out_buffer_valid_o),
    .out_buffer_ready_i (out_buffer_ready_i),
    .out_flush_buffers_o(out_flush_buffers_o)
  );

  // Reference model state
  logic [31:0] mq [NS][$];
  logic        fp [NS];
  logic [31:0] consumed_m [NS];
  logic [31:0] dropped_m [NS];
  logic [31:0] exp_rd;
  logic        exp_rvalid;

  int checks = 0;
  int passes = 0;

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      mq[s].delete();
      fp[s] = 1'b0;
      consumed_m[s] = '0;
      dropped_m[s] = '0;
    end
    exp_rd = '0;
    exp_rvalid = 1'b0;
  endfunction

  function automatic logic [31:0] model_reg(input logic [31:0] idx);
    int unsigned s, k;
    if (idx == 0) return ID;
    if (idx == 1) return NS;
    if (idx == 2) return DEPTH;
    if (idx >= 3 && idx < 3 + 3 * NS) begin
      s = (idx - 3) / 3;
      k = (idx - 3) % 3;
      if (k == 0) return 32'(mq[s].size());
      if (k == 1) return consumed_m[s];
      return dropped_m[s];
    end
    return '0;
  endfunction

  function automatic logic exp_valid(input int s);
    return (mq[s].size() != 0) && !fp[s];
  endfunction

  // Advance one clock: apply the current inputs to the model, clock the DUT,
  // then return the write/read strobes to idle.
  task automatic cycle();
    logic [31:0] rel, wd, rdv;
    logic        hit, rv;
    logic [NS-1:0] pop;
    rel = write_index_i - BASE;
    hit = write_valid_i && (write_index_i >= BASE);
    wd  = write_data_i;
    rv  = read_valid_i;
    rdv = model_reg(read_index_i);
    for (int s = 0; s < NS; s++) pop[s] = exp_valid(s) && out_buffer_ready_i[s];
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (fp[s]) begin
        mq[s].delete();
      end else begin
        if (pop[s]) void'(mq[s].pop_front());
        if (hit && rel == s) begin
          if (mq[s].size() < DEPTH) mq[s].push_back(wd);
          else if (dropped_m[s] != 32'hFFFF_FFFF) dropped_m[s] = dropped_m[s] + 1;
        end
      end
      if (pop[s]) consumed_m[s] = consumed_m[s] + 1;
      if (hit && rel == NS + 1 && wd[s]) begin
        consumed_m[s] = '0;
        dropped_m[s] = '0;
      end
      fp[s] = hit && rel == NS && wd[s];
    end
    exp_rvalid = rv;
    if (rv) exp_rd = rdv;
    write_valid_i = 1'b0;
    read_valid_i = 1'b0;
  endtask

  task automatic enq(input int unsigned s, input logic [31:0] d);
    write_valid_i = 1'b1;
    write_index_i = BASE + s;
    write_data_i = d;
    cycle();
  endtask

  task automatic read_reg(input logic [31:0] idx, output logic [31:0] got, output logic [31:0] exp);
    read_valid_i = 1'b1;
    read_index_i = idx;
    cycle();
    got = read_data_o;
    exp = exp_rd;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    rst_n = 1'b0;
    out_buffer_ready_i = '0;
    repeat (5) @(posedge clk);
    #1;
    model_reset();
    checks++; if (out_buffer_valid_o !== '0) $display("FAIL reset_valid: got %b want 0", out_buffer_valid_o); else passes++;
    checks++; if (out_flush_buffers_o !== '0) $display("FAIL reset_flush: got %b want 0", out_flush_buffers_o); else passes++;
    checks++; if (read_data_o !== '0) $display("FAIL reset_rdata: got %h want 0", read_data_o); else passes++;
    checks++; if (read_valid_o !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", read_valid_o); else passes++;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    read_reg(0, got, exp);
    checks++; if (got !== ID) $display("FAIL reg_id: got %h want %h", got, ID); else passes++;
    read_reg(1, got, exp);
    checks++; if (got !== 32'd2) $display("FAIL reg_num_streams: got %0d want 2", got); else passes++;
    read_reg(2, got, exp);
    checks++; if (got !== 32'd4) $display("FAIL reg_fifo_depth: got %0d want 4", got); else passes++;
    for (int i = 3; i < 12; i++) begin
      read_reg(i, got, exp);
      checks++; if (got !== 32'd0) $display("FAIL reset_reg[%0d]: got %h want 0", i, got); else passes++;
    end
  endtask

  task automatic test_fwft();
    logic [31:0] d [3];
    logic [31:0] got, exp;
    out_buffer_ready_i = '0;
    for (int k = 0; k < 3; k++) d[k] = $urandom;
    enq(1, d[0]);
    checks++; if (out_buffer_valid_o[1] !== 1'b1 || out_buffer_data_o[1] !== d[0])
      $display("FAIL fwft_first: got v=%b d=%h want v=1 d=%h", out_buffer_valid_o[1], out_buffer_data_o[1], d[0]); else passes++;
    enq(1, d[1]);
    enq(1, d[2]);
    read_reg(6, got, exp);
    checks++; if (got !== 32'd3) $display("FAIL fwft_occ_full: got %0d want 3", got); else passes++;
    checks++; if (out_buffer_valid_o[0] !== 1'b0) $display("FAIL fwft_s0_idle: got %b want 0", out_buffer_valid_o[0]); else passes++;
    out_buffer_ready_i = 2'b10;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_buffer_valid_o[1] !== 1'b1 || out_buffer_data_o[1] !== d[k])
        $display("FAIL fwft_drain[%0d]: got v=%b d=%h want v=1 d=%h", k, out_buffer_valid_o[1], out_buffer_data_o[1], d[k]); else passes++;
      cycle();
    end
    checks++; if (out_buffer_valid_o[1] !== 1'b0) $display("FAIL fwft_empty: got %b want 0", out_buffer_valid_o[1]); else passes++;
    out_buffer_ready_i = '0;
    read_reg(7, got, exp);
    checks++; if (got !== 32'd3) $display("FAIL fwft_consumed: got %0d want 3", got); else passes++;
    read_reg(6, got, exp);
    checks++; if (got !== 32'd0) $display("FAIL fwft_occ_empty: got %0d want 0", got); else passes++;
    read_reg(4, got, exp);
    checks++; if (got !== 32'd0) $display("FAIL fwft_s0_consumed: got %0d want 0", got); else passes++;
  endtask

  task automatic test_overflow();
    logic [31:0] d [6];
    logic [31:0] got, exp;
    out_buffer_ready_i = '0;
    for (int k = 0; k < 6; k++) begin
      d[k] = $urandom;
      enq(0, d[k]);
    end
    read_reg(3, got, exp);
    checks++; if (got !== 32'd4) $display("FAIL ovf_occ: got %0d want 4", got); else passes++;
    read_reg(5, got, exp);
    checks++; if (got !== 32'd2) $display("FAIL ovf_dropped: got %0d want 2", got); else passes++;
    out_buffer_ready_i = 2'b01;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_buffer_valid_o[0] !== 1'b1 || out_buffer_data_o[0] !== d[k])
        $display("FAIL ovf_drain[%0d]: got v=%b d=%h want v=1 d=%h", k, out_buffer_valid_o[0], out_buffer_data_o[0], d[k]); else passes++;
      cycle();
    end
    checks++; if (out_buffer_valid_o[0] !== 1'b0) $display("FAIL ovf_empty: got %b want 0", out_buffer_valid_o[0]); else passes++;
    out_buffer_ready_i = '0;
  endtask

  task automatic test_flush();
    logic [31:0] got, exp, cons0;
    out_buffer_ready_i = '0;
    for (int k = 0; k < 3; k++) enq(0, $urandom);
    for (int k = 0; k < 2; k++) enq(1, $urandom);
    read_reg(4, got, exp);
    cons0 = got;
    // Handshake on stream 0 in the same cycle as the flush write.
    out_buffer_ready_i = 2'b01;
    write_valid_i = 1'b1;
    write_index_i = BASE + NS;
    write_data_i = ($urandom & 32'hFFFF_FFFC) | 32'h1;
    cycle();
    checks++; if (out_flush_buffers_o !== 2'b01) $display("FAIL flush_pulse: got %b want 01", out_flush_buffers_o); else passes++;
    checks++; if (out_buffer_valid_o !== 2'b10) $display("FAIL flush_valid: got %b want 10", out_buffer_valid_o); else passes++;
    cycle();
    checks++; if (out_flush_buffers_o !== 2'b00) $display("FAIL flush_one_cycle: got %b want 00", out_flush_buffers_o); else passes++;
    checks++; if (out_buffer_valid_o[0] !== 1'b0) $display("FAIL flush_emptied: got %b want 0", out_buffer_valid_o[0]); else passes++;
    out_buffer_ready_i = '0;
    read_reg(3, got, exp);
    checks++; if (got !== 32'd0) $display("FAIL flush_occ0: got %0d want 0", got); else passes++;
    read_reg(6, got, exp);
    checks++; if (got !== 32'd2) $display("FAIL flush_occ1: got %0d want 2", got); else passes++;
    read_reg(4, got, exp);
    checks++; if (got !== cons0 + 32'd1) $display("FAIL flush_handshake_counted: got %0d want %0d", got, cons0 + 32'd1); else passes++;
    // Flush of an empty stream still pulses.
    write_valid_i = 1'b1;
    write_index_i = BASE + NS;
    write_data_i = 32'h1;
    cycle();
    checks++; if (out_flush_buffers_o !== 2'b01) $display("FAIL flush_empty_pulse: got %b want 01", out_flush_buffers_o); else passes++;
    // Empty stream 1 for the next scenario.
    write_valid_i = 1'b1;
    write_index_i = BASE + NS;
    write_data_i = 32'h2;
    cycle();
    checks++; if (out_flush_buffers_o !== 2'b10) $display("FAIL flush_s1_pulse: got %b want 10", out_flush_buffers_o); else passes++;
    cycle();
  endtask

  task automatic test_full_pushpop();
    logic [31:0] d [5];
    logic [31:0] got, exp, drop0;
    out_buffer_ready_i = '0;
    read_reg(5, got, exp);
    drop0 = got;
    for (int k = 0; k < 5; k++) d[k] = $urandom;
    for (int k = 0; k < 4; k++) enq(0, d[k]);
    out_buffer_ready_i = 2'b01;
    enq(0, d[4]);
    out_buffer_ready_i = '0;
    read_reg(3, got, exp);
    checks++; if (got !== 32'd4) $display("FAIL pushpop_occ: got %0d want 4", got); else passes++;
    read_reg(5, got, exp);
    checks++; if (got !== drop0) $display("FAIL pushpop_dropped: got %0d want %0d", got, drop0); else passes++;
    out_buffer_ready_i = 2'b01;
    for (int k = 1; k < 5; k++) begin
      checks++; if (out_buffer_valid_o[0] !== 1'b1 || out_buffer_data_o[0] !== d[k])
        $display("FAIL pushpop_drain[%0d]: got v=%b d=%h want v=1 d=%h", k, out_buffer_valid_o[0], out_buffer_data_o[0], d[k]); else passes++;
      cycle();
    end
    out_buffer_ready_i = '0;
  endtask

  task automatic test_clear();
    logic [31:0] got, exp;
    out_buffer_ready_i = '0;
    for (int k = 0; k < 6; k++) enq(1, $urandom);
    read_reg(8, got, exp);
    checks++; if (got !== 32'd2) $display("FAIL clear_pre_dropped1: got %0d want 2", got); else passes++;
    // Handshake on stream 1 in the clear cycle is lost.
    out_buffer_ready_i = 2'b10;
    write_valid_i = 1'b1;
    write_index_i = BASE + NS + 1;
    write_data_i = ($urandom & 32'hFFFF_FFFC) | 32'h2;
    cycle();
    out_buffer_ready_i = '0;
    read_reg(7, got, exp);
    checks++; if (got !== 32'd0) $display("FAIL clear_consumed1: got %0d want 0", got); else passes++;
    read_reg(8, got, exp);
    checks++; if (got !== 32'd0) $display("FAIL clear_dropped1: got %0d want 0", got); else passes++;
    read_reg(4, got, exp);
    checks++; if (got !== exp || got == 32'd0) $display("FAIL clear_keep_consumed0: got %0d want %0d", got, exp); else passes++;
    read_reg(5, got, exp);
    checks++; if (got !== 32'd2) $display("FAIL clear_keep_dropped0: got %0d want 2", got); else passes++;
    read_reg(6, got, exp);
    checks++; if (got !== 32'd3) $display("FAIL clear_occ1: got %0d want 3", got); else passes++;
  endtask

  task automatic test_reset_midop();
    logic [31:0] got, exp;
    out_buffer_ready_i = '0;
    enq(0, $urandom);
    enq(0, $urandom);
    cycle();
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++; if (out_flush_buffers_o !== '0) $display("FAIL rstmid_flush[%0d]: got %b want 0", k, out_flush_buffers_o); else passes++;
    end
    model_reset();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_buffer_valid_o !== '0) $display("FAIL rstmid_valid: got %b want 0", out_buffer_valid_o); else passes++;
    read_reg(3, got, exp);
    checks++; if (got !== 32'd0) $display("FAIL rstmid_occ0: got %0d want 0", got); else passes++;
    read_reg(6, got, exp);
    checks++; if (got !== 32'd0) $display("FAIL rstmid_occ1: got %0d want 0", got); else passes++;
  endtask

  task automatic test_random();
    int unsigned r;
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < NS; s++) begin
        checks++; if (out_buffer_valid_o[s] !== exp_valid(s))
          $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", s, c, out_buffer_valid_o[s], exp_valid(s)); else passes++;
        if (exp_valid(s)) begin
          checks++; if (out_buffer_data_o[s] !== mq[s][0])
            $display("FAIL rnd_data[%0d] cyc %0d: got %h want %h", s, c, out_buffer_data_o[s], mq[s][0]); else passes++;
        end
        checks++; if (out_flush_buffers_o[s] !== fp[s])
          $display("FAIL rnd_flush[%0d] cyc %0d: got %b want %b", s, c, out_flush_buffers_o[s], fp[s]); else passes++;
      end
      checks++; if (read_valid_o !== exp_rvalid) $display("FAIL rnd_rvalid cyc %0d: got %b want %b", c, read_valid_o, exp_rvalid); else passes++;
      checks++; if (read_data_o !== exp_rd) $display("FAIL rnd_rdata cyc %0d: got %h want %h", c, read_data_o, exp_rd); else passes++;

      out_buffer_ready_i = NS'($urandom);
      r = $urandom_range(0, 11);
      if (r <= 5) begin
        write_valid_i = 1'b1;
        write_index_i = BASE + $urandom_range(0, NS - 1);
        write_data_i = $urandom;
      end else if (r == 6) begin
        write_valid_i = 1'b1;
        write_index_i = BASE + NS;
        write_data_i = $urandom;
      end else if (r == 7 && $urandom_range(0, 3) == 0) begin
        write_valid_i = 1'b1;
        write_index_i = BASE + NS + 1;
        write_data_i = $urandom;
      end else if (r == 8) begin
        write_valid_i = 1'b1;
        write_index_i = ($urandom_range(0, 1) == 0) ? BASE - 1 : BASE + NS + 2 + $urandom_range(0, 50);
        write_data_i = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        read_valid_i = 1'b1;
        read_index_i = $urandom_range(0, 12);
      end
      cycle();
    end
    out_buffer_ready_i = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fwft();
    test_overflow();
    test_flush();
    test_full_pushpop();
    test_clear();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
